// File: rtl/aether_mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NumReq burst clients.
// Optional idle-beat watchdog enabled by defining AETHER_ARB_TIMEOUT_EN.
module aether_mem_arbiter #(
  parameter int NumReq        = 7,
  parameter int AddrWidth     = 25,
  parameter int DataWidth     = 16,
  parameter int LenWidth      = 9,
  parameter int TimeoutCycles = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              req_we_i,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq*LenWidth-1:0]     req_len_i,
  input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              wr_ready_o,
  output logic [NumReq-1:0]              rd_valid_o,
  output logic [DataWidth-1:0]           rd_data_o,
  output logic [NumReq-1:0]              done_o,
  output logic                           busy_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [LenWidth-1:0]            mem_len_o,
  input  logic                           mem_ack_i,
  output logic [DataWidth-1:0]           mem_wdata_o,
  input  logic                           mem_wr_ready_i,
  input  logic                           mem_rd_valid_i,
  input  logic [DataWidth-1:0]           mem_rd_data_i,
  output logic                           err_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_e;

  state_e                state_r, state_s;
  logic [PtrW-1:0]       rr_ptr_r, owner_r, pick_s;
  logic                  found_s;
  logic                  we_r, mem_req_r;
  logic [AddrWidth-1:0]  addr_r;
  logic [LenWidth-1:0]   len_r, cnt_r;
  logic [NumReq-1:0]     gnt_r, owner_oh_s;
  logic                  beat_s, last_s, abort_s;

  function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumReq) begin
      sum = sum - NumReq;
    end else begin
      sum = sum;
    end
    return PtrW'(sum);
  endfunction

  function automatic logic [NumReq-1:0] onehot(input logic [PtrW-1:0] idx);
    logic [NumReq-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Rotating priority search starting at rr_ptr_r.
  always_comb begin
    pick_s  = '0;
    found_s = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found_s && req_i[wrap_idx(rr_ptr_r, i)]) begin
        found_s = 1'b1;
        pick_s  = wrap_idx(rr_ptr_r, i);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign owner_oh_s = onehot(owner_r);
  assign beat_s     = (state_r == XFER) && (we_r ? mem_wr_ready_i : mem_rd_valid_i);
  assign last_s     = beat_s && (cnt_r == len_r);

`ifdef AETHER_ARB_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);

  logic [WdW-1:0] wdog_r;
  logic           err_r;
  logic           activity_s;

  assign activity_s = ((state_r == ISSUE) && mem_ack_i) || beat_s;
  assign abort_s    = (state_r != IDLE) && !activity_s && (wdog_r == WdW'(TimeoutCycles - 1));
  assign err_o      = err_r;

  // Idle-beat watchdog and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_r <= '0;
      err_r  <= 1'b0;
    end else begin
      if ((state_r == IDLE) || activity_s || abort_s) begin
        wdog_r <= '0;
      end else begin
        wdog_r <= wdog_r + WdW'(1);
      end
      if (abort_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end
`else
  assign abort_s = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: begin
        if (abort_s)        state_s = IDLE;
        else if (mem_ack_i) state_s = XFER;
        else                state_s = ISSUE;
      end
      XFER: begin
        if (abort_s || last_s) state_s = IDLE;
        else                   state_s = XFER;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, grant, latched command and beat counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
      gnt_r     <= '0;
      mem_req_r <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            owner_r   <= pick_s;
            we_r      <= req_we_i[pick_s];
            addr_r    <= req_addr_i[int'(pick_s)*AddrWidth +: AddrWidth];
            len_r     <= req_len_i[int'(pick_s)*LenWidth +: LenWidth];
            gnt_r     <= onehot(pick_s);
            rr_ptr_r  <= wrap_idx(pick_s, 1);
            mem_req_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (abort_s || mem_ack_i) begin
            mem_req_r <= 1'b0;
            cnt_r     <= '0;
          end
        end
        XFER: begin
          if (beat_s && !last_s) begin
            cnt_r <= cnt_r + LenWidth'(1);
          end
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_r;
  assign busy_o      = (state_r != IDLE);
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = we_r;
  assign mem_addr_o  = addr_r;
  assign mem_len_o   = len_r;
  assign mem_wdata_o = req_wdata_i[int'(owner_r)*DataWidth +: DataWidth];
  assign rd_data_o   = mem_rd_data_i;
  assign wr_ready_o  = (beat_s && we_r)  ? owner_oh_s : '0;
  assign rd_valid_o  = (beat_s && !we_r) ? owner_oh_s : '0;
  assign done_o      = (last_s || abort_s) ? owner_oh_s : '0;

endmodule

// File: tb/tb_aether_mem_arbiter.sv
// Directed self-checking bench for aether_mem_arbiter (TimeoutCycles = 16).
module tb_aether_mem_arbiter;

  localparam int NumReq    = 7;
  localparam int AddrWidth = 25;
  localparam int DataWidth = 16;
  localparam int LenWidth  = 9;
`ifdef AETHER_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic [NumReq-1:0]           req_i, req_we_i;
  logic [NumReq*AddrWidth-1:0] req_addr_i;
  logic [NumReq*LenWidth-1:0]  req_len_i;
  logic [NumReq*DataWidth-1:0] req_wdata_i;
  logic [NumReq-1:0]           gnt_o, wr_ready_o, rd_valid_o, done_o;
  logic [DataWidth-1:0]        rd_data_o, mem_wdata_o, mem_rd_data_i;
  logic                        busy_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [AddrWidth-1:0]        mem_addr_o;
  logic [LenWidth-1:0]         mem_len_o;
  logic                        mem_wr_ready_i, mem_rd_valid_i, err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int nb;
  logic rdy;
  logic [5:0] pat;

  aether_mem_arbiter #(.TimeoutCycles(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .wr_ready_o(wr_ready_o), .rd_valid_o(rd_valid_o),
    .rd_data_o(rd_data_o), .done_o(done_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_len_o(mem_len_o), .mem_ack_i(mem_ack_i), .mem_wdata_o(mem_wdata_o),
    .mem_wr_ready_i(mem_wr_ready_i), .mem_rd_valid_i(mem_rd_valid_i),
    .mem_rd_data_i(mem_rd_data_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [NumReq-1:0] oh(input int i);
    return 7'd1 << i;
  endfunction

  function automatic logic [127:0] outs();
    return {gnt_o, wr_ready_o, rd_valid_o, done_o, busy_o, mem_req_o, mem_we_o,
            mem_addr_o, mem_len_o, err_o, rd_data_o, mem_wdata_o};
  endfunction

  // One len=0 write transaction for the requester expected to win arbitration.
  task automatic xact_w0(input int e);
    tick();
    chk("rr_gnt", gnt_o, oh(e));
    chk("rr_we", mem_we_o, 1'b1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i      = 1'b0;
    mem_wr_ready_i = 1'b1;
    #1;
    chk("rr_wr_ready", wr_ready_o, oh(e));
    chk("rr_done", done_o, oh(e));
    chk("rr_wdata", mem_wdata_o, 16'hA000 + 16'(e));
    tick();
    mem_wr_ready_i = 1'b0;
    #1;
    chk("rr_bubble", busy_o, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; req_i = '0; req_we_i = '0; req_addr_i = '0; req_len_i = '0;
    req_wdata_i = '0; mem_ack_i = 1'b0; mem_wr_ready_i = 1'b0;
    mem_rd_valid_i = 1'b0; mem_rd_data_i = '0;
    repeat (3) tick();
    chk("reset_outs", outs(), 128'd0);
    rst_ni = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_outs", outs(), 128'd0);
    end

    // Single read on requester 3
    req_i[3] = 1'b1;
    req_addr_i[3*AddrWidth +: AddrWidth] = 25'h000100;
    req_len_i[3*LenWidth +: LenWidth]    = 9'd3;
    #1;
    chk("rd_gnt_latency", gnt_o, 7'd0);
    tick();
    chk("rd_gnt", gnt_o, oh(3));
    chk("rd_addr", mem_addr_o, 25'h000100);
    chk("rd_len", mem_len_o, 9'd3);
    chk("rd_mem_req", mem_req_o, 1'b1);
    req_i = '0;
    tick();
    chk("rd_gnt_once", gnt_o, 7'd0);
    chk("rd_mem_req_hold", mem_req_o, 1'b1);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("rd_mem_req_drop", mem_req_o, 1'b0);
    chk("rd_busy", busy_o, 1'b1);
    pat = 6'b101101;
    nb  = 0;
    for (int c = 0; c < 6; c++) begin
      mem_rd_valid_i = pat[c];
      mem_rd_data_i  = 16'hD000 + 16'(c);
      mem_wr_ready_i = (c == 1 || c == 2);
      #1;
      if (pat[c]) nb++;
      chk("rd_valid", rd_valid_o, pat[c] ? oh(3) : 7'd0);
      chk("rd_data", rd_data_o, 16'hD000 + 16'(c));
      chk("rd_wrong_dir", wr_ready_o, 7'd0);
      chk("rd_done", done_o, (pat[c] && nb == 4) ? oh(3) : 7'd0);
      tick();
    end
    mem_rd_valid_i = 1'b0; mem_wr_ready_i = 1'b0; mem_rd_data_i = '0;
    #1;
    chk("rd_busy_after", busy_o, 1'b0);
    chk("rd_beat_count", nb, 4);

    // Round robin from a fresh reset
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    req_i = '1; req_we_i = '1; req_len_i = '0;
    for (int i = 0; i < NumReq; i++) req_wdata_i[i*DataWidth +: DataWidth] = 16'hA000 + 16'(i);
    for (int t = 0; t < 8; t++) xact_w0(t % NumReq);

    // Fairness after wrap: move rr_ptr to 5, then requests 0 and 1
    req_i = oh(4);
    xact_w0(4);
    req_i = 7'b0000011;
    xact_w0(0);
    xact_w0(1);
    req_i = '0;

    // Maximum length write on requester 1 with stray read strobes
    req_len_i[1*LenWidth +: LenWidth]       = 9'd511;
    req_wdata_i[1*DataWidth +: DataWidth]   = 16'h5A5A;
    req_i = oh(1);
    tick();
    chk("max_gnt", gnt_o, oh(1));
    chk("max_len", mem_len_o, 9'd511);
    chk("max_wdata", mem_wdata_o, 16'h5A5A);
    req_i = '0; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    nb = 0;
    for (int c = 0; c < 700 && nb < 512; c++) begin
      rdy = (c % 5 != 4);
      mem_wr_ready_i = rdy;
      mem_rd_valid_i = (c % 7 == 3);
      #1;
      if (rdy) nb++;
      chk("max_wr_ready", wr_ready_o, rdy ? oh(1) : 7'd0);
      chk("max_stray_rd", rd_valid_o, 7'd0);
      chk("max_done", done_o, (rdy && nb == 512) ? oh(1) : 7'd0);
      tick();
    end
    mem_wr_ready_i = 1'b0; mem_rd_valid_i = 1'b0;
    #1;
    chk("max_beats", nb, 512);
    chk("max_busy_after", busy_o, 1'b0);

    // Reset in the middle of an 8-beat read on requester 2
    req_wdata_i = '0; req_we_i = '0;
    req_len_i[2*LenWidth +: LenWidth]    = 9'd7;
    req_addr_i[2*AddrWidth +: AddrWidth] = 25'h1ABCDE;
    req_i = oh(2);
    tick();
    chk("mid_gnt", gnt_o, oh(2));
    chk("mid_addr", mem_addr_o, 25'h1ABCDE);
    req_i = '0; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mem_rd_valid_i = 1'b1;
      #1;
      chk("mid_rd_valid", rd_valid_o, oh(2));
      tick();
    end
    mem_rd_valid_i = 1'b0;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_reset_outs", outs(), 128'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Withheld ack on requester 5
    req_i = oh(5);
    tick();
    chk("to_gnt", gnt_o, oh(5));
    req_i = '0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("to_done", done_o, (ToEn && k == 16) ? oh(5) : 7'd0);
      chk("to_busy", busy_o, 1'b1);
      tick();
    end
`ifdef AETHER_ARB_TIMEOUT_EN
    chk("to_abort_busy", busy_o, 1'b0);
    chk("to_abort_req", mem_req_o, 1'b0);
    chk("to_err", err_o, 1'b1);
    repeat (3) tick();
    chk("to_err_sticky", err_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("to_err_reset", err_o, 1'b0);
`else
    repeat (24) tick();
    chk("to_wait_busy", busy_o, 1'b1);
    chk("to_wait_req", mem_req_o, 1'b1);
    chk("to_no_err", err_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("to_reset_req", mem_req_o, 1'b0);
`endif
    tick();
    rst_ni = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
